// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage load/store requests: one request at a time,
// serviced from a word-organised SRAM after WAIT_CYCLES wait states, one-cycle response.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    accept, access;

  logic                    lat_we;
  logic [31:0]             lat_addr, lat_wdata;
  logic [3:0]              lat_be;

  logic                    acc_we;
  logic [31:0]             acc_addr, acc_wdata;
  logic [3:0]              acc_be;
  logic                    acc_err;
  logic [ADDR_WIDTH-1:0]   acc_idx;

  logic [31:0]             mem [DEPTH];

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && req_ready;

  // With zero wait states the access edge is the accept edge, so the request
  // fields are used directly; otherwise the latched copy drives the access.
  always_comb begin
    if (state == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    acc_idx = acc_addr[ADDR_WIDTH+1:2];
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    access     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_next = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            access     = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = S_RESP;
          access     = 1'b1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (access) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // NOTE: the SRAM array has no reset; only the write is qualified by rst so a held request cannot commit during reset.
  always_ff @(posedge clk) begin
    if (rst && access && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule
